// File: rtl/pong_pkg.sv
// Shared types, default geometry and sizing helpers for the Pong ball engine.
// Exports: pong_state_e, DEF_* geometry constants, vel_width, acc_width, clamp_u.
package pong_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_SERVE_WAIT = 2'd1,
        ST_MOVE       = 2'd2,
        ST_SCORED     = 2'd3
    } pong_state_e;

    localparam int DEF_H_VIDEO = 640;
    localparam int DEF_V_VIDEO = 480;
    localparam int DEF_BALL    = 16;
    localparam int DEF_PDL_W   = 12;
    localparam int DEF_PDL_H   = 96;
    localparam int DEF_PDL1_X  = 24;
    localparam int DEF_PDL2_X  = 603;

    // Bits needed to hold the larger of the two speed ceilings.
    function automatic int vel_width(input int max_x, input int max_y);
        int m;
        m = (max_x > max_y) ? max_x : max_y;
        return $clog2(m + 1);
    endfunction

    // Headroom above the threshold so a velocity above it cannot wrap soon.
    function automatic int acc_width(input int clk_hz, input int vel_w);
        return $clog2(clk_hz + 1) + vel_w + 2;
    endfunction

    function automatic logic [31:0] clamp_u(input logic [31:0] v, input int lim);
        return (v > 32'(lim)) ? 32'(lim) : v;
    endfunction

endpackage

// File: rtl/pong_axis_stepper.sv
// Sub-pixel accumulator for one axis; strobes step_o when a pixel move is due.
// Ports: clk_0, rst (async low), en_i, clr_i, vel_i (px/s), step_o.
module pong_axis_stepper
    import pong_pkg::*;
#(
    parameter int ACC_W  = 32,
    parameter int VEL_W  = 10,
    parameter int THRESH = 1000
) (
    input  logic             clk_0,
    input  logic             rst,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [VEL_W-1:0] vel_i,
    output logic             step_o
);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic             over;

    // The threshold test uses the value before this cycle's add.
    always_comb begin
        over   = acc_q >= ACC_W'(THRESH);
        step_o = en_i & over;
        acc_d  = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            if (over) acc_d = acc_q - ACC_W'(THRESH) + ACC_W'(vel_i);
            else      acc_d = acc_q + ACC_W'(vel_i);
        end
    end

    always_ff @(posedge clk_0 or negedge rst) begin
        if (!rst) acc_q <= '0;
        else      acc_q <= acc_d;
    end

endmodule

// File: rtl/pong_ball_engine.sv
// Ball physics: serve, motion, wall/paddle bounces, goals and event pulses.
// Ports: clk_0, rst (async low), serve/serve_dir/serve_y, pause, abort,
//   pdl1_ypos/pdl2_ypos in; ball_xpos/ball_ypos/ball_shown, state,
//   goal_p1/goal_p2/paddle_hit/wall_bounce pulses, hit_side, hit_offset,
//   rally_count out.
// Option: PONG_RALLY_SPEEDUP_EN ramps x speed with rally_count.
module pong_ball_engine
    import pong_pkg::*;
#(
    parameter int H_VIDEO     = DEF_H_VIDEO,
    parameter int V_VIDEO     = DEF_V_VIDEO,
    parameter int BALL        = DEF_BALL,
    parameter int PDL_W       = DEF_PDL_W,
    parameter int PDL_H       = DEF_PDL_H,
    parameter int PDL1_X      = DEF_PDL1_X,
    parameter int PDL2_X      = DEF_PDL2_X,
    parameter int CLK_HZ      = 25_175_000,
    parameter int BASE_XVEL   = 300,
    parameter int RALLY_STEP  = 25,
    parameter int MAX_XVEL    = 600,
    parameter int YVEL_MIN    = 60,
    parameter int YVEL_SCALE  = 10,
    parameter int YVEL_MAX    = 480,
    parameter int SERVE_DELAY = 50_350_112,
    parameter int RALLY_W     = 6
) (
    input  logic               clk_0,
    input  logic               rst,
    input  logic               serve,
    input  logic               serve_dir,
    input  logic [9:0]         serve_y,
    input  logic               pause,
    input  logic               abort,
    input  logic [9:0]         pdl1_ypos,
    input  logic [9:0]         pdl2_ypos,
    output logic [9:0]         ball_xpos,
    output logic [9:0]         ball_ypos,
    output logic               ball_shown,
    output logic [1:0]         state,
    output logic               goal_p1,
    output logic               goal_p2,
    output logic               paddle_hit,
    output logic               hit_side,
    output logic [6:0]         hit_offset,
    output logic               wall_bounce,
    output logic [RALLY_W-1:0] rally_count
);

    localparam int VEL_W  = vel_width(MAX_XVEL, YVEL_MAX);
    localparam int PROD_W = VEL_W + RALLY_W;
    localparam int ACC_W  = acc_width(CLK_HZ, VEL_W);
    localparam int DLY_W  = (SERVE_DELAY > 2) ? $clog2(SERVE_DELAY) : 1;
    localparam int X_CTR  = H_VIDEO / 2 - BALL / 2;
    localparam int Y_CTR  = V_VIDEO / 2 - BALL / 2;
    localparam int X_GOAL = H_VIDEO - BALL;
    localparam int Y_MAX  = V_VIDEO - BALL;
    localparam int X_PDL2 = PDL2_X - BALL;
    localparam int X_PDL1 = PDL1_X + PDL_W;
    localparam int HALF_H = PDL_H / 2;

    pong_state_e        state_q;
    logic [9:0]         x_q, y_q;
    logic               xdir_q, ydir_q, shown_q;
    logic               goal1_q, goal2_q, hit_q, wall_q, side_q;
    logic [6:0]         hoff_q;
    logic [RALLY_W-1:0] rally_q;
    logic [DLY_W-1:0]   dly_q;

    logic [VEL_W-1:0]   xvel, yvel;
    logic [PROD_W-1:0]  ysum;
    logic               xstep, ystep, run, clr;

`ifdef PONG_RALLY_SPEEDUP_EN
    logic [PROD_W-1:0]  xsum;
    assign xsum = PROD_W'(BASE_XVEL) + PROD_W'(RALLY_STEP) * PROD_W'(rally_q);
    assign xvel = VEL_W'(clamp_u(32'(xsum), MAX_XVEL));
`else
    assign xvel = VEL_W'(BASE_XVEL);
`endif

    assign ysum = PROD_W'(YVEL_MIN) + PROD_W'(YVEL_SCALE) * PROD_W'(hoff_q);
    assign yvel = VEL_W'(clamp_u(32'(ysum), YVEL_MAX));

    assign run = (state_q == ST_MOVE) & ~pause;
    assign clr = (state_q != ST_MOVE);

    pong_axis_stepper #(
        .ACC_W (ACC_W),
        .VEL_W (VEL_W),
        .THRESH(CLK_HZ)
    ) u_xstep (
        .clk_0 (clk_0),
        .rst   (rst),
        .en_i  (run),
        .clr_i (clr),
        .vel_i (xvel),
        .step_o(xstep)
    );

    pong_axis_stepper #(
        .ACC_W (ACC_W),
        .VEL_W (VEL_W),
        .THRESH(CLK_HZ)
    ) u_ystep (
        .clk_0 (clk_0),
        .rst   (rst),
        .en_i  (run),
        .clr_i (clr),
        .vel_i (yvel),
        .step_o(ystep)
    );

    logic        ovl1, ovl2, p_hit, g1, g2, wall_c, ydir_new;
    logic        xdir_d, ydir_d;
    logic [9:0]  x_d, y_d, pad_y, sy;
    logic [10:0] c_w, p_w, diff_w;
    logic [6:0]  hoff_d;

    always_comb begin
        ovl2 = (11'(y_q) + 11'(BALL) > 11'(pdl2_ypos)) &&
               (11'(y_q) < 11'(pdl2_ypos) + 11'(PDL_H));
        ovl1 = (11'(y_q) + 11'(BALL) > 11'(pdl1_ypos)) &&
               (11'(y_q) < 11'(pdl1_ypos) + 11'(PDL_H));
        pad_y  = xdir_q ? pdl2_ypos : pdl1_ypos;
        c_w    = 11'(y_q) + 11'(BALL / 2);
        p_w    = 11'(pad_y) + 11'(HALF_H);
        diff_w = (c_w >= p_w) ? c_w - p_w : p_w - c_w;
        hoff_d = (diff_w > 11'(HALF_H)) ? 7'(HALF_H) : diff_w[6:0];
        sy     = (serve_y > 10'(Y_MAX)) ? 10'(Y_MAX) : serve_y;

        x_d    = x_q;
        xdir_d = xdir_q;
        p_hit  = 1'b0;
        g1     = 1'b0;
        g2     = 1'b0;
        if (xstep) begin
            if (xdir_q) begin
                if (x_q == 10'(X_PDL2) && ovl2) begin
                    p_hit  = 1'b1;
                    xdir_d = 1'b0;
                end else if (32'(x_q) + 32'd1 >= 32'(X_GOAL)) begin
                    x_d = 10'(X_GOAL);
                    g1  = 1'b1;
                end else begin
                    x_d = x_q + 10'd1;
                end
            end else begin
                if (x_q == 10'(X_PDL1) && ovl1) begin
                    p_hit  = 1'b1;
                    xdir_d = 1'b1;
                end else if (x_q == 10'd0) begin
                    g2 = 1'b1;
                end else begin
                    x_d = x_q - 10'd1;
                end
            end
        end

        // A paddle bounce in the same cycle steers the y step too.
        ydir_new = p_hit ? (c_w >= p_w) : ydir_q;
        y_d      = y_q;
        ydir_d   = ydir_new;
        wall_c   = 1'b0;
        if (ystep) begin
            if (ydir_new) begin
                if (y_q >= 10'(Y_MAX)) begin
                    ydir_d = 1'b0;
                    wall_c = 1'b1;
                end else begin
                    y_d = y_q + 10'd1;
                end
            end else begin
                if (y_q == 10'd0) begin
                    ydir_d = 1'b1;
                    wall_c = 1'b1;
                end else begin
                    y_d = y_q - 10'd1;
                end
            end
        end
    end

    always_ff @(posedge clk_0 or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            x_q     <= 10'(X_CTR);
            y_q     <= 10'(Y_CTR);
            xdir_q  <= 1'b0;
            ydir_q  <= 1'b0;
            shown_q <= 1'b0;
            goal1_q <= 1'b0;
            goal2_q <= 1'b0;
            hit_q   <= 1'b0;
            wall_q  <= 1'b0;
            side_q  <= 1'b0;
            hoff_q  <= '0;
            rally_q <= '0;
            dly_q   <= '0;
        end else begin
            goal1_q <= 1'b0;
            goal2_q <= 1'b0;
            hit_q   <= 1'b0;
            wall_q  <= 1'b0;
            if (abort) begin
                state_q <= ST_IDLE;
                x_q     <= 10'(X_CTR);
                y_q     <= 10'(Y_CTR);
                shown_q <= 1'b0;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (serve) begin
                            state_q <= ST_SERVE_WAIT;
                            x_q     <= 10'(X_CTR);
                            y_q     <= sy;
                            xdir_q  <= serve_dir;
                            ydir_q  <= serve_y[0];
                            rally_q <= '0;
                            hoff_q  <= '0;
                            dly_q   <= '0;
                        end
                    end
                    ST_SERVE_WAIT: begin
                        shown_q <= 1'b0;
                        if (32'(dly_q) + 32'd1 >= 32'(SERVE_DELAY)) begin
                            state_q <= ST_MOVE;
                            shown_q <= 1'b1;
                        end else begin
                            dly_q <= dly_q + 1'b1;
                        end
                    end
                    ST_MOVE: begin
                        x_q    <= x_d;
                        y_q    <= y_d;
                        xdir_q <= xdir_d;
                        ydir_q <= ydir_d;
                        wall_q <= wall_c;
                        if (p_hit) begin
                            hit_q  <= 1'b1;
                            side_q <= xdir_q;
                            hoff_q <= hoff_d;
                            if (rally_q != '1) rally_q <= rally_q + 1'b1;
                        end
                        if (g1 | g2) begin
                            goal1_q <= g1;
                            goal2_q <= g2;
                            shown_q <= 1'b0;
                            state_q <= ST_SCORED;
                        end
                    end
                    ST_SCORED: state_q <= ST_IDLE;
                    default:   state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign ball_xpos   = x_q;
    assign ball_ypos   = y_q;
    assign ball_shown  = shown_q;
    assign state       = state_q;
    assign goal_p1     = goal1_q;
    assign goal_p2     = goal2_q;
    assign paddle_hit  = hit_q;
    assign hit_side    = side_q;
    assign hit_offset  = hoff_q;
    assign wall_bounce = wall_q;
    assign rally_count = rally_q;

endmodule

// File: tb/tb_pong_ball_engine.sv
// Directed bench for pong_ball_engine with a fast 1000 Hz accumulator.
// Serve, paddle bounce, wall bounce, goals, pause, abort and reset checks.
module tb_pong_ball_engine;

    logic       clk_0 = 1'b0;
    logic       rst = 1'b0;
    logic       serve = 1'b0, serve_dir = 1'b0, pause = 1'b0, abort = 1'b0;
    logic [9:0] serve_y = '0, pdl1_ypos = 10'd300, pdl2_ypos = 10'd100;
    logic [9:0] ball_xpos, ball_ypos;
    logic       ball_shown, goal_p1, goal_p2, paddle_hit, hit_side, wall_bounce;
    logic [1:0] state;
    logic [6:0] hit_offset;
    logic [5:0] rally_count;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk_0 = ~clk_0;

    pong_ball_engine #(
        .CLK_HZ     (1000),
        .BASE_XVEL  (1000),
        .RALLY_STEP (25),
        .MAX_XVEL   (2000),
        .YVEL_MIN   (0),
        .YVEL_SCALE (10),
        .YVEL_MAX   (480),
        .SERVE_DELAY(4),
        .RALLY_W    (6)
    ) dut (
        .clk_0      (clk_0),
        .rst        (rst),
        .serve      (serve),
        .serve_dir  (serve_dir),
        .serve_y    (serve_y),
        .pause      (pause),
        .abort      (abort),
        .pdl1_ypos  (pdl1_ypos),
        .pdl2_ypos  (pdl2_ypos),
        .ball_xpos  (ball_xpos),
        .ball_ypos  (ball_ypos),
        .ball_shown (ball_shown),
        .state      (state),
        .goal_p1    (goal_p1),
        .goal_p2    (goal_p2),
        .paddle_hit (paddle_hit),
        .hit_side   (hit_side),
        .hit_offset (hit_offset),
        .wall_bounce(wall_bounce),
        .rally_count(rally_count)
    );

    task automatic tick();
        @(posedge clk_0);
        #1;
    endtask

    task automatic do_serve(input logic dir, input logic [9:0] y);
        serve_dir = dir;
        serve_y   = y;
        serve     = 1'b1;
        tick();
        serve     = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        vectors++;
        if (state !== 2'd0 || ball_xpos !== 10'd312 || ball_ypos !== 10'd232) begin
            miscompares++;
            $display("FAIL reset_pos: st=%0d x=%0d y=%0d want 0/312/232", state, ball_xpos, ball_ypos);
        end
        vectors++;
        if ({ball_shown, goal_p1, goal_p2, paddle_hit, wall_bounce, hit_side} !== 6'd0 ||
            hit_offset !== 7'd0 || rally_count !== 6'd0) begin
            miscompares++;
            $display("FAIL reset_flags: shown=%b hit=%b off=%0d rally=%0d want zeros",
                     ball_shown, paddle_hit, hit_offset, rally_count);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_serve();
        int n;
        pdl2_ypos = 10'd100;
        pdl1_ypos = 10'd300;
        do_serve(1'b1, 10'd100);
        vectors++;
        if (state !== 2'd1 || ball_shown !== 1'b0 || ball_ypos !== 10'd100) begin
            miscompares++;
            $display("FAIL serve_entry: st=%0d shown=%b y=%0d want 1/0/100", state, ball_shown, ball_ypos);
        end
        n = 0;
        while (ball_shown !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        vectors++;
        if (n !== 4 || state !== 2'd2) begin
            miscompares++;
            $display("FAIL serve_delay: cycles=%0d st=%0d want 4/2", n, state);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (ball_xpos !== 10'(312 + i)) begin
                miscompares++;
                $display("FAIL serve_move%0d: x=%0d want %0d", i, ball_xpos, 312 + i);
            end
        end
    endtask

    task automatic test_paddle_hit();
        int n;
        logic [10:0] exp_xvel;
`ifdef PONG_RALLY_SPEEDUP_EN
        exp_xvel = 11'd1025;
`else
        exp_xvel = 11'd1000;
`endif
        n = 0;
        while (paddle_hit !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        vectors++;
        if (n >= 400) begin
            miscompares++;
            $display("FAIL paddle_timeout: no paddle_hit within %0d cycles", n);
        end
        vectors++;
        if (ball_xpos !== 10'd587 || ball_ypos !== 10'd100 || hit_side !== 1'b1) begin
            miscompares++;
            $display("FAIL paddle_pos: x=%0d y=%0d side=%b want 587/100/1", ball_xpos, ball_ypos, hit_side);
        end
        vectors++;
        if (hit_offset !== 7'd40 || rally_count !== 6'd1) begin
            miscompares++;
            $display("FAIL paddle_offset: off=%0d rally=%0d want 40/1", hit_offset, rally_count);
        end
        vectors++;
        if (dut.xvel !== exp_xvel) begin
            miscompares++;
            $display("FAIL paddle_xvel: xvel=%0d want %0d", dut.xvel, exp_xvel);
        end
        tick();
        vectors++;
        if (paddle_hit !== 1'b0 || hit_side !== 1'b1 || ball_xpos !== 10'd586) begin
            miscompares++;
            $display("FAIL paddle_after: hit=%b side=%b x=%0d want 0/1/586", paddle_hit, hit_side, ball_xpos);
        end
    endtask

    task automatic test_wall_bounce();
        int n;
        n = 0;
        while (wall_bounce !== 1'b1 && n < 600) begin
            tick();
            n++;
        end
        vectors++;
        if (n >= 600 || ball_ypos !== 10'd0) begin
            miscompares++;
            $display("FAIL wall_bounce: cycles=%0d y=%0d want <600/0", n, ball_ypos);
        end
        n = 0;
        while (ball_ypos === 10'd0 && n < 10) begin
            tick();
            n++;
        end
        vectors++;
        if (ball_ypos !== 10'd1) begin
            miscompares++;
            $display("FAIL wall_next: y=%0d want 1", ball_ypos);
        end
    endtask

    task automatic test_reset_mid_move();
        vectors++;
        if (state !== 2'd2) begin
            miscompares++;
            $display("FAIL pre_reset_state: st=%0d want 2", state);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if (state !== 2'd0 || ball_xpos !== 10'd312 || ball_ypos !== 10'd232 ||
            ball_shown !== 1'b0 || rally_count !== 6'd0 || hit_offset !== 7'd0) begin
            miscompares++;
            $display("FAIL reset_mid: st=%0d x=%0d y=%0d shown=%b rally=%0d off=%0d want 0/312/232/0/0/0",
                     state, ball_xpos, ball_ypos, ball_shown, rally_count, hit_offset);
        end
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_goal_p1();
        int n;
        pdl2_ypos = 10'd300;
        do_serve(1'b1, 10'd100);
        n = 0;
        while (goal_p1 !== 1'b1 && n < 500) begin
            tick();
            n++;
        end
        vectors++;
        if (n >= 500 || ball_xpos !== 10'd624 || ball_ypos !== 10'd100) begin
            miscompares++;
            $display("FAIL goal_p1: cycles=%0d x=%0d y=%0d want <500/624/100", n, ball_xpos, ball_ypos);
        end
        vectors++;
        if (state !== 2'd3 || ball_shown !== 1'b0 || goal_p2 !== 1'b0 || rally_count !== 6'd0) begin
            miscompares++;
            $display("FAIL goal_p1_flags: st=%0d shown=%b g2=%b rally=%0d want 3/0/0/0",
                     state, ball_shown, goal_p2, rally_count);
        end
        tick();
        vectors++;
        if (state !== 2'd0 || goal_p1 !== 1'b0 || ball_xpos !== 10'd624) begin
            miscompares++;
            $display("FAIL goal_p1_after: st=%0d g1=%b x=%0d want 0/0/624", state, goal_p1, ball_xpos);
        end
    endtask

    task automatic test_goal_p2();
        int n;
        pdl1_ypos = 10'd300;
        do_serve(1'b0, 10'd100);
        n = 0;
        while (goal_p2 !== 1'b1 && n < 500) begin
            tick();
            n++;
        end
        vectors++;
        if (n >= 500 || ball_xpos !== 10'd0 || state !== 2'd3 || goal_p1 !== 1'b0) begin
            miscompares++;
            $display("FAIL goal_p2: cycles=%0d x=%0d st=%0d g1=%b want <500/0/3/0", n, ball_xpos, state, goal_p1);
        end
        tick();
        vectors++;
        if (state !== 2'd0 || goal_p2 !== 1'b0 || ball_shown !== 1'b0 || ball_xpos !== 10'd0) begin
            miscompares++;
            $display("FAIL goal_p2_after: st=%0d g2=%b shown=%b x=%0d want 0/0/0/0",
                     state, goal_p2, ball_shown, ball_xpos);
        end
    endtask

    task automatic test_pause();
        int n;
        do_serve(1'b0, 10'd101);
        n = 0;
        while (ball_shown !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        tick();
        tick();
        tick();
        vectors++;
        if (ball_xpos !== 10'd310) begin
            miscompares++;
            $display("FAIL pause_pre: x=%0d want 310", ball_xpos);
        end
        pause = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            vectors++;
            if (ball_xpos !== 10'd310 || ball_ypos !== 10'd101 || state !== 2'd2) begin
                miscompares++;
                $display("FAIL pause_hold%0d: x=%0d y=%0d st=%0d want 310/101/2", i, ball_xpos, ball_ypos, state);
            end
        end
        pause = 1'b0;
        tick();
        vectors++;
        if (ball_xpos !== 10'd309) begin
            miscompares++;
            $display("FAIL pause_release: x=%0d want 309", ball_xpos);
        end
    endtask

    task automatic test_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        vectors++;
        if (state !== 2'd0 || ball_xpos !== 10'd312 || ball_ypos !== 10'd232 || ball_shown !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_move: st=%0d x=%0d y=%0d shown=%b want 0/312/232/0",
                     state, ball_xpos, ball_ypos, ball_shown);
        end
        do_serve(1'b1, 10'd500);
        vectors++;
        if (state !== 2'd1 || ball_ypos !== 10'd464) begin
            miscompares++;
            $display("FAIL serve_clamp: st=%0d y=%0d want 1/464", state, ball_ypos);
        end
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        vectors++;
        if (state !== 2'd0 || goal_p1 !== 1'b0 || goal_p2 !== 1'b0 || ball_ypos !== 10'd232) begin
            miscompares++;
            $display("FAIL abort_wait: st=%0d g1=%b g2=%b y=%0d want 0/0/0/232",
                     state, goal_p1, goal_p2, ball_ypos);
        end
        for (int i = 0; i < 6; i++) tick();
        vectors++;
        if (state !== 2'd0 || ball_shown !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_stays_idle: st=%0d shown=%b want 0/0", state, ball_shown);
        end
        abort = 1'b1;
        serve = 1'b1;
        tick();
        abort = 1'b0;
        serve = 1'b0;
        vectors++;
        if (state !== 2'd0) begin
            miscompares++;
            $display("FAIL abort_beats_serve: st=%0d want 0", state);
        end
    endtask

    initial begin
        test_reset();
        test_serve();
        test_paddle_hit();
        test_wall_bounce();
        test_reset_mid_move();
        test_goal_p1();
        test_goal_p2();
        test_pause();
        test_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
